// File: rtl/viterbi_pkg.sv
// ============================================================================
// Module      : viterbi_pkg
// Description : Shared defaults and FSM state encoding for the Viterbi
//               decoder controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package viterbi_pkg;

    localparam int VIT_FRAME_LEN  = 8;
    localparam int VIT_NUM_ST     = 4;
    localparam int VIT_PM_W       = 8;
    localparam int VIT_TB_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACS    = 3'd1,
        ST_SELECT = 3'd2,
        ST_TRACE  = 3'd3,
        ST_OUT    = 3'd4
    } vit_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_min_sel.sv
// ============================================================================
// Module      : viterbi_min_sel
// Description : Combinational argmin over packed path metrics; ties go to
//               the lowest state index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_min_sel
    import viterbi_pkg::*;
#(
    parameter int NUM_ST = VIT_NUM_ST,
    parameter int PM_W   = VIT_PM_W
) (
    input  logic [NUM_ST*PM_W-1:0]         i_pm,
    output logic [safe_clog2(NUM_ST)-1:0]  o_idx
);

    localparam int IDX_W = safe_clog2(NUM_ST);

    logic [PM_W-1:0]  w_best_val;
    logic [IDX_W-1:0] w_best_idx;

    // Strict less-than keeps the earlier (lower) index on equal metrics.
    always_comb begin
        w_best_val = i_pm[PM_W-1:0];
        w_best_idx = '0;
        for (int k = 1; k < NUM_ST; k++) begin
            if (i_pm[k*PM_W +: PM_W] < w_best_val) begin
                w_best_val = i_pm[k*PM_W +: PM_W];
                w_best_idx = IDX_W'(k);
            end
        end
    end

    assign o_idx = w_best_idx;

endmodule

`default_nettype wire

// File: rtl/viterbi_controller.sv
// ============================================================================
// Module      : viterbi_controller
// Description : Frame sequencer for a Viterbi decoder: ACS stepping,
//               survivor-memory addressing, start-state select, traceback
//               supervision with timeout, and output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_controller
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN  = VIT_FRAME_LEN,
    parameter int NUM_ST     = VIT_NUM_ST,
    parameter int PM_W       = VIT_PM_W,
    parameter int TB_TIMEOUT = VIT_TB_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_sym_valid,
    output logic                              o_sym_ready,
    output logic                              o_en_acs,
    output logic                              o_first_stage,
    output logic                              o_sm_wr_en,
    output logic [safe_clog2(FRAME_LEN)-1:0]  o_sm_addr,
    input  logic [NUM_ST*PM_W-1:0]            i_pm,
    output logic [safe_clog2(NUM_ST)-1:0]     o_sel_node,
    output logic                              o_en_t,
    input  logic                              i_tb_done,
    output logic                              o_out_valid,
    input  logic                              i_out_ready,
    output logic                              o_busy,
    output logic                              o_err
);

    localparam int SA_W  = safe_clog2(FRAME_LEN);
    localparam int SEL_W = safe_clog2(NUM_ST);
    localparam int TB_W  = $clog2(TB_TIMEOUT + 1);

    localparam logic [SA_W-1:0] c_LAST_STAGE = SA_W'(FRAME_LEN - 1);
    localparam logic [TB_W-1:0] c_TB_LAST    = TB_W'(TB_TIMEOUT - 1);

    vit_state_e       r_state;
    logic [SA_W-1:0]  r_stage;
    logic [TB_W-1:0]  r_tb_cnt;
    logic [SEL_W-1:0] r_sel_node;
    logic             r_err;

    logic             w_ready;
    logic             w_accept;
    logic [SEL_W-1:0] w_min_idx;

    viterbi_min_sel #(
        .NUM_ST (NUM_ST),
        .PM_W   (PM_W)
    ) u_min_sel (
        .i_pm   (i_pm),
        .o_idx  (w_min_idx)
    );

    // Every output is forced low while rst is held, including the
    // combinational handshake terms that would otherwise see i_sym_valid.
    assign w_ready  = ~rst & ((r_state == ST_IDLE) | (r_state == ST_ACS));
    assign w_accept = i_sym_valid & w_ready;

    assign o_sym_ready   = w_ready;
    assign o_en_acs      = w_accept;
    assign o_sm_wr_en    = w_accept;
    assign o_first_stage = w_accept & (r_stage == '0);
    assign o_sm_addr     = rst ? '0 : r_stage;
    assign o_sel_node    = rst ? '0 : r_sel_node;
    assign o_en_t        = ~rst & (r_state == ST_TRACE);
    assign o_out_valid   = ~rst & (r_state == ST_OUT);
    assign o_busy        = ~rst & (r_state != ST_IDLE);
    assign o_err         = ~rst & r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stage    <= '0;
            r_tb_cnt   <= '0;
            r_sel_node <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACS: begin
                    if (w_accept) begin
                        if (r_stage == c_LAST_STAGE) begin
                            r_state <= ST_SELECT;
                            r_stage <= '0;
                        end else begin
                            r_state <= ST_ACS;
                            r_stage <= r_stage + 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    r_sel_node <= w_min_idx;
                    r_tb_cnt   <= '0;
                    r_state    <= ST_TRACE;
                end
                ST_TRACE: begin
                    // A done arriving on the final allowed cycle still counts.
                    if (i_tb_done) begin
                        r_state <= ST_OUT;
                    end else if (r_tb_cnt == c_TB_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tb_cnt <= r_tb_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_viterbi_controller.sv
// ============================================================================
// Module      : tb_viterbi_controller
// Description : Self-checking bench for viterbi_controller: vector table,
//               directed corner sequences and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_controller;

    localparam int FL = 8;
    localparam int NS = 4;
    localparam int PW = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sym_valid;
    logic        o_sym_ready;
    logic        o_en_acs;
    logic        o_first_stage;
    logic        o_sm_wr_en;
    logic [2:0]  o_sm_addr;
    logic [31:0] i_pm;
    logic [1:0]  o_sel_node;
    logic        o_en_t;
    logic        i_tb_done;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_busy;
    logic        o_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_err = 1'b0;

    viterbi_controller #(
        .FRAME_LEN  (FL),
        .NUM_ST     (NS),
        .PM_W       (PW),
        .TB_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_sym_valid   (i_sym_valid),
        .o_sym_ready   (o_sym_ready),
        .o_en_acs      (o_en_acs),
        .o_first_stage (o_first_stage),
        .o_sm_wr_en    (o_sm_wr_en),
        .o_sm_addr     (o_sm_addr),
        .i_pm          (i_pm),
        .o_sel_node    (o_sel_node),
        .o_en_t        (o_en_t),
        .i_tb_done     (i_tb_done),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pm;
        int          sel;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_argmin(input logic [31:0] pm);
        int best_i = 0;
        int best_v = pm[7:0];
        for (int k = 1; k < NS; k++) begin
            if (int'(pm[k*PW +: PW]) < best_v) begin
                best_v = int'(pm[k*PW +: PW]);
                best_i = k;
            end
        end
        return best_i;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sym_ready"}, o_sym_ready, 0);
        check({tag, "_en_acs"}, o_en_acs, 0);
        check({tag, "_first"}, o_first_stage, 0);
        check({tag, "_wr_en"}, o_sm_wr_en, 0);
        check({tag, "_addr"}, o_sm_addr, 0);
        check({tag, "_sel"}, o_sel_node, 0);
        check({tag, "_en_t"}, o_en_t, 0);
        check({tag, "_out_valid"}, o_out_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_err"}, o_err, 0);
    endtask

    // One complete frame starting from IDLE; done_cyc outside 1..TO means
    // traceback never reports done, so a timeout is expected.
    task automatic do_frame(input logic [31:0] pm, input int exp_sel,
                            input int done_cyc, input int stall, input bit rnd);
        int cnt   = 0;
        int guard = 0;
        bit v;
        bit timed_out;
        i_pm = pm;
        while (cnt < FL && guard < 200) begin
            v           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_sym_valid = v;
            i_tb_done   = 1'($urandom_range(0, 1));
            i_out_ready = 1'($urandom_range(0, 1));
            #1;
            check("feed_ready", o_sym_ready, 1);
            check("feed_en_acs", o_en_acs, int'(v));
            check("feed_wr_en", o_sm_wr_en, int'(v));
            check("feed_addr", o_sm_addr, cnt);
            check("feed_first", o_first_stage, int'(v && cnt == 0));
            check("feed_busy", o_busy, int'(cnt != 0));
            check("feed_en_t", o_en_t, 0);
            check("feed_err", o_err, int'(exp_err));
            tick();
            if (v) cnt++;
            guard++;
        end
        if (cnt < FL) check("feed_budget", cnt, FL);

        i_sym_valid = 1'b1;
        i_tb_done   = 1'b1;
        i_out_ready = 1'b1;
        #1;
        check("sel_ready", o_sym_ready, 0);
        check("sel_en_acs", o_en_acs, 0);
        check("sel_wr_en", o_sm_wr_en, 0);
        check("sel_en_t", o_en_t, 0);
        check("sel_busy", o_busy, 1);
        check("sel_out_valid", o_out_valid, 0);
        tick();

        timed_out = !(done_cyc >= 1 && done_cyc <= TO);
        for (int t = 1; t <= TO; t++) begin
            i_tb_done   = (t == done_cyc);
            i_out_ready = 1'($urandom_range(0, 1));
            i_sym_valid = 1'($urandom_range(0, 1));
            #1;
            check("trace_en_t", o_en_t, 1);
            check("trace_sel_node", o_sel_node, exp_sel);
            check("trace_ready", o_sym_ready, 0);
            check("trace_en_acs", o_en_acs, 0);
            check("trace_out_valid", o_out_valid, 0);
            tick();
            if (t == done_cyc) break;
        end
        i_tb_done = 1'b0;

        if (timed_out) begin
            exp_err     = 1'b1;
            i_sym_valid = 1'b0;
            #1;
            check("to_err", o_err, 1);
            check("to_busy", o_busy, 0);
            check("to_en_t", o_en_t, 0);
            check("to_out_valid", o_out_valid, 0);
            tick();
        end else begin
            for (int s = 0; s < stall; s++) begin
                i_out_ready = 1'b0;
                i_tb_done   = 1'($urandom_range(0, 1));
                i_sym_valid = 1'b1;
                #1;
                check("out_valid_hold", o_out_valid, 1);
                check("out_en_t", o_en_t, 0);
                check("out_busy", o_busy, 1);
                check("out_ready", o_sym_ready, 0);
                tick();
            end
            i_out_ready = 1'b1;
            #1;
            check("out_valid_acc", o_out_valid, 1);
            tick();
            i_out_ready = 1'b0;
            i_sym_valid = 1'b0;
            i_tb_done   = 1'b0;
            #1;
            check("post_busy", o_busy, 0);
            check("post_out_valid", o_out_valid, 0);
            check("post_err", o_err, int'(exp_err));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [31:0] pm;

        vecs[0] = '{pm: {8'd9,   8'd3,   8'd3,   8'd12},  sel: 1};
        vecs[1] = '{pm: {8'd5,   8'd5,   8'd5,   8'd5},   sel: 0};
        vecs[2] = '{pm: {8'd0,   8'd1,   8'd2,   8'd3},   sel: 3};
        vecs[3] = '{pm: {8'd255, 8'd254, 8'd255, 8'd255}, sel: 2};
        vecs[4] = '{pm: {8'd128, 8'd200, 8'd7,   8'd7},   sel: 0};
        vecs[5] = '{pm: {8'd0,   8'd0,   8'd255, 8'd255}, sel: 2};

        rst         = 1'b1;
        i_sym_valid = 1'b1;
        i_tb_done   = 1'b1;
        i_out_ready = 1'b1;
        i_pm        = '0;
        #1;
        check_all_zero("rst_pre");
        tick();
        tick();
        check_all_zero("rst_held");
        rst         = 1'b0;
        i_sym_valid = 1'b0;
        i_tb_done   = 1'b0;
        i_out_ready = 1'b0;
        #1;
        check("rst_rel_busy", o_busy, 0);
        check("rst_rel_ready", o_sym_ready, 1);
        tick();

        // Vector table: first entry is the 8-symbol, done-on-3rd, 4-cycle stall case.
        for (int i = 0; i < 6; i++) begin
            do_frame(vecs[i].pm, vecs[i].sel, 3 + i, (4 + i) % 5, 1'b0);
        end

        do_frame(vecs[0].pm, 1, 0, 0, 1'b0);
        do_frame(vecs[2].pm, 3, 2, 1, 1'b1);
        do_frame(vecs[3].pm, 2, TO, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < NS; k++) pm[k*PW +: PW] = 8'($urandom_range(0, 15));
            do_frame(pm, model_argmin(pm), int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of a frame.
        i_pm = vecs[1].pm;
        for (int s = 0; s < 5; s++) begin
            i_sym_valid = 1'b1;
            #1;
            check("mid_addr", o_sm_addr, s);
            tick();
        end
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        rst         = 1'b0;
        i_sym_valid = 1'b0;
        exp_err     = 1'b0;
        #1;
        check("mid_post_busy", o_busy, 0);
        check("mid_post_addr", o_sm_addr, 0);
        check("mid_post_err", o_err, 0);
        tick();
        do_frame(vecs[1].pm, 0, 1, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/viterbi_controller.md
VITERBI_CONTROLLER -- requirements
Module: viterbi_controller

Interface
REQ-001 Parameters SHALL be: FRAME_LEN, default 8, trellis stages per frame; NUM_ST, default 4, trellis states; PM_W, default 8, path-metric width; TB_TIMEOUT, default 16, maximum TRACE cycles.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_sym_valid  in  1  received symbol pair present.
- o_sym_ready  out  1  controller accepts symbol.
- o_en_acs  out  1  datapath ACS/branch-metric update this cycle.
- o_first_stage  out  1  ACS uses initial metrics (state 0 = 0, others = max).
- o_sm_wr_en  out  1  survivor-memory write strobe.
- o_sm_addr  out  clog2(FRAME_LEN)  survivor-memory write address.
- i_pm  in  NUM_ST*PM_W  packed path metrics; state k at bits [k*PM_W +: PM_W].
- o_sel_node  out  clog2(NUM_ST)  traceback start state.
- o_en_t  out  1  traceback enable.
- i_tb_done  in  1  traceback finished; decoded word valid.
- o_out_valid  out  1  decoded frame available downstream.
- i_out_ready  in  1  downstream accepts frame.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  sticky traceback-timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, ACS, SELECT, TRACE, OUT.
REQ-004 o_sym_ready SHALL be 1 in IDLE and ACS, 0 elsewhere and 0 while rst is high.
REQ-005 accept = i_sym_valid & o_sym_ready; o_en_acs and o_sm_wr_en SHALL equal accept combinationally.
REQ-006 o_sm_addr SHALL equal stage counter; counter SHALL increment on each accept and clear on entry to SELECT.
REQ-007 o_first_stage SHALL be accept & (stage counter == 0).
REQ-008 IDLE -> ACS on accept with counter 0; ACS -> SELECT on accept with counter == FRAME_LEN-1; no accept leaves state and counter unchanged.
REQ-009 SELECT SHALL last exactly one cycle, registering o_sel_node = index of minimum i_pm entry (unsigned); ties resolve to lowest index; then -> TRACE.
REQ-010 o_en_t SHALL be 1 in every TRACE cycle only; o_sel_node SHALL hold stable throughout TRACE.
REQ-011 TRACE -> OUT on i_tb_done; TRACE cycle counter reaching TB_TIMEOUT without i_tb_done SHALL set o_err and -> IDLE.
REQ-012 i_tb_done and timeout in the same cycle: done wins, o_err unchanged.
REQ-013 o_out_valid SHALL be 1 in OUT only; OUT -> IDLE when i_out_ready is 1; o_out_valid SHALL not drop before acceptance.
REQ-014 i_tb_done outside TRACE and i_out_ready outside OUT SHALL be ignored.
REQ-015 Minimum latency: last symbol accept -> o_en_t high is 2 cycles (SELECT, then TRACE).
REQ-016 o_err SHALL stay set until rst.

Reset
REQ-017 rst high at a clock edge SHALL force IDLE, stage and TRACE counters 0, o_sel_node 0, o_err 0, from any state including mid-frame.
REQ-018 While rst is high all outputs SHALL be 0; combinational outputs SHALL be gated.
REQ-019 The first symbol after rst deasserts SHALL start a fresh frame with o_first_stage 1.

Structure
REQ-020 Shared package viterbi_pkg SHALL hold FRAME_LEN, NUM_ST, PM_W, TB_TIMEOUT defaults and the FSM state enum.
REQ-021 Argmin logic SHALL be sub-module viterbi_min_sel (combinational, parameterised by NUM_ST and PM_W).
REQ-022 All registered state SHALL be on clk only; no latches.

Verification
REQ-023 8 back-to-back symbols: o_sm_addr 0..7, o_first_stage only on first, o_en_t high 2 cycles after 8th accept.
REQ-024 i_pm = {9,3,3,12} (states 3..0): o_sel_node = 1.
REQ-025 i_tb_done on 3rd TRACE cycle, i_out_ready low 4 cycles: o_out_valid held 4+ cycles; IDLE after ready.
REQ-026 No i_tb_done: o_err set after 16 TRACE cycles, IDLE; next frame runs normally, o_err stays 1.
REQ-027 rst pulsed after 5th symbol: IDLE, counter 0; next accept has o_first_stage 1, o_sm_addr 0.
REQ-028 i_sym_valid toggled every other cycle: exactly 8 writes, no address skip or repeat.
